// File: rtl/clock_pkg.sv
// Shared types and calendar helpers for the time keeper: the packed time word,
// the qualifier states and the month-length function.
package clock_pkg;

  typedef struct packed {
    logic       header;
    logic [4:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
  } time_t;

  localparam int         REF_YEAR = 2014;
  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} qual_state_t;

  // No century rule is needed: the 5-bit year only spans 2014-2045.
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [4:0] year);
    logic leap;
    leap = ((int'(year) + REF_YEAR) % 4) == 0;
    case (month)
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/word_stabilizer.sv
// Two-flop synchronizer for the packed time word plus a saturating counter of
// consecutive identical synchronized samples; stable flags a settled word.
module word_stabilizer
  import clock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 64
) (
  input  logic  clk,
  input  logic  reset,
  input  time_t din,
  output time_t dout,
  output logic  stable
);

  localparam int unsigned     CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  time_t         meta_q, meta_d;
  time_t         sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    cnt_d  = cnt_q;
    // The sample that differs is itself the first of the new run.
    if (sync_d != sync_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout   = sync_q;
  assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/time_keeper.sv
// Qualifies time packets from the SPI receiver and runs a 1 Hz calendar clock.
// Optional stale-sync flag enabled by defining TIME_KEEPER_SYNC_TIMEOUT_EN.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 40000000,
  parameter int unsigned STABLE_CYCLES = 64
`ifdef TIME_KEEPER_SYNC_TIMEOUT_EN
  , parameter int unsigned SYNC_TIMEOUT_S = 7200
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_header,
  input  logic [4:0] in_year,
  input  logic [3:0] in_month,
  input  logic [4:0] in_day,
  input  logic [4:0] in_hour,
  input  logic [5:0] in_minute,
  input  logic [5:0] in_second,
  output logic [4:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       tick,
  output logic       loaded,
  output logic       load_err,
  output logic       synced,
  output logic       fresh,
  output logic       stale
);

  localparam int unsigned   PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam time_t         TIME_RST  = '{header: 1'b0, year: 5'd0, month: 4'd1, day: 5'd1,
                                          hour: 5'd0, minute: 6'd0, second: 6'd0};

  time_t in_word;
  time_t sync_word;
  logic  stable;

  assign in_word = {in_header, in_year, in_month, in_day, in_hour, in_minute, in_second};

  word_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk   (clk),
    .reset (reset),
    .din   (in_word),
    .dout  (sync_word),
    .stable(stable)
  );

  qual_state_t   state_q, state_d;
  time_t         last_q, last_d;
  time_t         cand_q, cand_d;
  time_t         cur_q, cur_d;   // cur_q.header is the fresh flag
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          loaded_q, loaded_d;
  logic          load_err_q, load_err_d;
  logic          synced_q, synced_d;
  logic          cand_ok;

  always_comb begin
    cand_ok = (cand_q.hour <= MAX_HOUR) && (cand_q.minute <= MAX_MIN) &&
              (cand_q.second <= MAX_SEC) && (cand_q.month >= 4'd1) &&
              (cand_q.month <= 4'd12) && (cand_q.day >= 5'd1) &&
              (cand_q.day <= days_in_month(cand_q.month, cand_q.year));
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cand_d     = cand_q;
    cur_d      = cur_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    loaded_d   = 1'b0;
    load_err_d = 1'b0;
    synced_d   = synced_q;

    case (state_q)
      IDLE: begin
        if (sync_word != last_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (sync_word == last_q) begin
          state_d = IDLE;
        end else if (stable) begin
          // Freeze the settled word so a change during CHECK cannot slip in.
          state_d = CHECK;
          cand_d  = sync_word;
        end
      end
      CHECK: begin
        state_d = IDLE;
        last_d  = cand_q;
        if (cand_ok) begin
          loaded_d = 1'b1;
          synced_d = 1'b1;
        end else begin
          load_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (loaded_d) begin
      cur_d   = cand_q;
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (cur_q.second != MAX_SEC) begin
        cur_d.second = cur_q.second + 6'd1;
      end else begin
        cur_d.second = 6'd0;
        if (cur_q.minute != MAX_MIN) begin
          cur_d.minute = cur_q.minute + 6'd1;
        end else begin
          cur_d.minute = 6'd0;
          if (cur_q.hour != MAX_HOUR) begin
            cur_d.hour = cur_q.hour + 5'd1;
          end else begin
            cur_d.hour = 5'd0;
            if (cur_q.day != days_in_month(cur_q.month, cur_q.year)) begin
              cur_d.day = cur_q.day + 5'd1;
            end else begin
              cur_d.day = 5'd1;
              if (cur_q.month != 4'd12) begin
                cur_d.month = cur_q.month + 4'd1;
              end else begin
                cur_d.month = 4'd1;
                cur_d.year  = cur_q.year + 5'd1;
              end
            end
          end
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      cand_q     <= '0;
      cur_q      <= TIME_RST;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
      synced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cand_q     <= cand_d;
      cur_q      <= cur_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      loaded_q   <= loaded_d;
      load_err_q <= load_err_d;
      synced_q   <= synced_d;
    end
  end

`ifdef TIME_KEEPER_SYNC_TIMEOUT_EN
  localparam int unsigned   SW       = $clog2(SYNC_TIMEOUT_S + 1);
  localparam logic [SW-1:0] SECS_MAX = SW'(SYNC_TIMEOUT_S);

  logic [SW-1:0] secs_q, secs_d;
  logic          stale_q, stale_d;

  always_comb begin
    secs_d = secs_q;
    if (loaded_d) begin
      secs_d = '0;
    end else if (tick_d && (secs_q != SECS_MAX)) begin
      secs_d = secs_q + SW'(1);
    end
    stale_d = (secs_d >= SECS_MAX) || !synced_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secs_q  <= '0;
      stale_q <= 1'b1;
    end else begin
      secs_q  <= secs_d;
      stale_q <= stale_d;
    end
  end

  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

  assign year     = cur_q.year;
  assign month    = cur_q.month;
  assign day      = cur_q.day;
  assign hour     = cur_q.hour;
  assign minute   = cur_q.minute;
  assign second   = cur_q.second;
  assign fresh    = cur_q.header;
  assign tick     = tick_q;
  assign loaded   = loaded_q;
  assign load_err = load_err_q;
  assign synced   = synced_q;

endmodule
